// File: rtl/seq_restoring_divider_16.sv
// rtl/seq_restoring_divider_16.sv - unsigned 16-bit sequential restoring divider
// Each trial subtraction runs through a 16-bit CLA built from 4-bit lookahead groups with rippled group carries.

module cla_16_bit_with_ripple (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_c0,
  output logic [15:0] o_sum,
  output logic        o_c16
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  always_comb begin
    o_sum = '0;
    w_p   = '0;
    w_g   = '0;
    w_c   = {4'b0000, i_c0};
    for (int k = 0; k < 4; k++) begin
      w_p    = i_a[4*k +: 4] ^ i_b[4*k +: 4];
      w_g    = i_a[4*k +: 4] & i_b[4*k +: 4];
      w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      o_sum[4*k +: 4] = w_p ^ w_c[3:0];
      // group carry-out ripples into the next group's carry-in
      w_c[0] = w_c[4];
    end
    o_c16 = w_c[0];
  end

endmodule

module seq_restoring_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;

  logic             w_t;
  logic [WIDTH-1:0] w_rs;
  logic [WIDTH-1:0] w_nd;
  logic [WIDTH-1:0] w_diff;
  logic             w_c16;
  logic             w_ok;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  assign w_t  = r_r[WIDTH-1];
  assign w_rs = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_nd = ~r_d;

  cla_16_bit_with_ripple u_cla (
    .i_a   (w_rs),
    .i_b   (w_nd),
    .i_c0  (1'b1),
    .o_sum (w_diff),
    .o_c16 (w_c16)
  );

  // A shifted-out 1 means the true remainder exceeds any 16-bit divisor.
  assign w_ok     = w_t | w_c16;
  assign w_r_next = w_ok ? w_diff : w_rs;
  assign w_q_next = {r_q[WIDTH-2:0], w_ok};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_d         <= divisor;
            r_q         <= dividend;
            r_r         <= '0;
            r_cnt       <= '0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        S_RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            quotient  <= w_q_next;
            remainder <= w_r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider_16.sv
// tb/tb_seq_restoring_divider_16.sv - bench for seq_restoring_divider_16
// Reference results come from plain / and % with the divide-by-zero convention.

module tb_seq_restoring_divider_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_restoring_divider_16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'hFFFF : a / b;
  endfunction

  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? a : a % b;
  endfunction

  // Issues a start from an IDLE negedge and waits for done; lat counts the cycles including the start cycle's edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                        output logic got_done);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (done === 1'b1) got_done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b dz=%0b q=%0h r=%0h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] a_tab [3] = '{16'd100, 16'hFFFF, 16'hFFFF};
    logic [15:0] b_tab [3] = '{16'd7, 16'h0001, 16'h8000};
    logic [15:0] q_tab [3] = '{16'd14, 16'hFFFF, 16'd1};
    logic [15:0] r_tab [3] = '{16'd2, 16'd0, 16'h7FFF};
    int lat;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      run_op(a_tab[i], b_tab[i], lat, ok);
      total++;
      if (!ok || lat != 17) begin
        bad++; $display("FAIL basic_latency[%0d]: got done=%0b lat=%0d, want lat=17", i, ok, lat);
      end
      total++;
      if (quotient !== q_tab[i] || remainder !== r_tab[i] || div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL basic_result[%0d]: got q=%0h r=%0h dz=%0b, want q=%0h r=%0h dz=0",
                 i, quotient, remainder, div_by_zero, q_tab[i], r_tab[i]);
      end
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL basic_busy_in_done[%0d]: got %0b want 1", i, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic ok;
    run_op(16'd1234, 16'd0, lat, ok);
    total++;
    if (!ok || lat != 1) begin
      bad++; $display("FAIL dz_latency: got done=%0b lat=%0d, want lat=1", ok, lat);
    end
    total++;
    if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dz_result: got q=%0h r=%0d dz=%0b, want q=ffff r=1234 dz=1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    run_op(16'd10, 16'd3, lat, ok);
    total++;
    if (!ok || quotient !== 16'd3 || remainder !== 16'd1 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL dz_clear: got done=%0b q=%0d r=%0d dz=%0b, want q=3 r=1 dz=0",
               ok, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    logic ok;
    start = 1'b1; dividend = 16'd5; divisor = 16'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    lat++;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done === 1'b1) ok = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    total++;
    if (!ok || lat != 17) begin
      bad++; $display("FAIL ignore_latency: got done=%0b lat=%0d, want lat=17", ok, lat);
    end
    total++;
    if (quotient !== 16'd0 || remainder !== 16'd5) begin
      bad++; $display("FAIL ignore_result: got q=%0d r=%0d, want q=0 r=5", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int pulses;
    logic ok;
    start = 1'b1; dividend = 16'd1000; divisor = 16'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
      bad++;
      $display("FAIL midrun_reset: got busy=%0b done=%0b dz=%0b q=%0h r=%0h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL midrun_no_done: got %0d pulses want 0", pulses);
    end
    run_op(16'd40000, 16'd300, lat, ok);
    total++;
    if (!ok || lat != 17 || quotient !== 16'd133 || remainder !== 16'd100) begin
      bad++;
      $display("FAIL midrun_fresh: got done=%0b lat=%0d q=%0d r=%0d, want lat=17 q=133 r=100",
               ok, lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic ok;
    logic [15:0] a, b;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'd1;
        2:       b = 16'hFFFF;
        3:       b = 16'($urandom_range(2, 255));
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      run_op(a, b, lat, ok);
      total++;
      if (!ok || lat != ((b == 16'd0) ? 1 : 17)) begin
        bad++; $display("FAIL rand_latency[%0d]: %0h/%0h got done=%0b lat=%0d", n, a, b, ok, lat);
      end
      total++;
      if (quotient !== ref_q(a, b) || remainder !== ref_r(a, b) || div_by_zero !== (b == 16'd0)) begin
        bad++;
        $display("FAIL rand_result[%0d]: %0h/%0h got q=%0h r=%0h dz=%0b, want q=%0h r=%0h dz=%0b",
                 n, a, b, quotient, remainder, div_by_zero, ref_q(a, b), ref_r(a, b), b == 16'd0);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL rand_idle_after_done[%0d]: got busy=%0b done=%0b want 0 0", n, busy, done);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_ignore_start;
    test_reset_mid_run;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
